sha256_msg_schedule: RTL and testbench

Sequential SHA-256 message-schedule generator for the discrete-logic datapath. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready input, then emits the 64 schedule words W0..W63 over a valid/ready output. The round/compression stage sits downstream and consumes these words. The sigma functions built here are pure XOR/shift networks, so they tech-map onto 74x86 XOR packages. The 16-word window maps onto shift-register chips.

---
 rtl/sha256_pkg.sv | 29 ++
 rtl/sha256_sigma.sv | 17 +
 rtl/sha256_msg_schedule.sv | 105 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule generator.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned SCHED_WORDS = 64;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned IDX_W       = 6;

    // Rotate/shift amounts for the two sigma networks
    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Rotate right by a constant amount (pure wiring)
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Small-sigma XOR network: SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned SEL = 0
) (
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    localparam int unsigned ROT_A = (SEL == 0) ? S0_ROT_A : S1_ROT_A;
    localparam int unsigned ROT_B = (SEL == 0) ? S0_ROT_B : S1_ROT_B;
    localparam int unsigned SHR   = (SEL == 0) ? S0_SHR   : S1_SHR;

    assign y_o = rotr(x_i, ROT_A) ^ rotr(x_i, ROT_B) ^ (x_i >> SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// Loads a 16-word block, then streams the 64 SHA-256 schedule words W0..W63.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(BLOCK_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [31:0]       w_q [BLOCK_WORDS];
    logic              shift_en;
    logic [31:0]       fill_word;
    logic [31:0]       sig0, sig1, next_w;

    sha256_sigma #(.SEL(0)) u_sigma0 (.x_i(w_q[1]),  .y_o(sig0));
    sha256_sigma #(.SEL(1)) u_sigma1 (.x_i(w_q[14]), .y_o(sig1));

    // Next schedule word from the current window, modulo 2^32
    assign next_w = sig1 + w_q[9] + sig0 + w_q[0];

    // Next-state, counter and window-shift control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        fill_word = in_word;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                fill_word = next_w;
                if (out_ready) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
        last_d = (state_d == ST_RUN) && (cnt_d == LAST_IDX);
    end

    // FSM, counter, last flag and 16-word window registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            if (shift_en) begin
                for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                    w_q[i] <= w_q[i+1];
                end
                w_q[BLOCK_WORDS-1] <= fill_word;
            end
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign out_word  = w_q[0];
    assign out_idx   = cnt_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule against an array-based schedule model.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];
    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          abc_chk = 1'b0;
    logic [31:0] known [int];

    sha256_msg_schedule #(.ROUNDS(64), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 schedule expansion over a plain array
    function automatic void ref_sched(input blk_t m, output sch_t w);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
    endfunction

    // Monitor: compares every output handshake and checks hold under backpressure
    exp_t        mon_e;
    bit          stall_prev = 1'b0;
    logic [31:0] hold_w;
    logic [5:0]  hold_i;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else if (out_valid) begin
            if (stall_prev) begin
                chk("hold_word", out_word, hold_w);
                chk("hold_idx", 32'(out_idx), 32'(hold_i));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got idx %0d word %h want no output", out_idx, out_word);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_word", out_word, mon_e.w);
                    chk("out_idx", 32'(out_idx), 32'(mon_e.idx));
                    chk("out_last", 32'(out_last), 32'(mon_e.last));
                    if (abc_chk && known.exists(int'(out_idx)))
                        chk("abc_known", out_word, known[int'(out_idx)]);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                hold_w     = out_word;
                hold_i     = out_idx;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
    endtask

    // Feed one block; expectations are queued once the 16th word is accepted
    task automatic load_block(input blk_t m, input bit gapped, input bit keep_valid);
        int   i;
        int   n;
        bit   tog;
        bit   hs;
        sch_t w;
        i   = 0;
        n   = 0;
        tog = 1'b1;
        while (i < 16 && n < 200) begin
            in_valid = gapped ? tog : 1'b1;
            tog      = ~tog;
            in_word  = m[i];
            @(negedge clk);
            hs = in_valid && in_ready;
            chk("load_no_early_valid", 32'(out_valid), 32'd0);
            chk("load_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            n++;
            if (hs) i++;
        end
        if (i < 16) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d words accepted want 16", i);
        end
        if (!keep_valid) in_valid = 1'b0;
        ref_sched(m, w);
        for (int t = 0; t < 64; t++) exp_q.push_back('{w[t], 6'(t), (t == 63)});
    endtask

    // Drain the schedule with optional stall, input noise, reset or next-block preload
    task automatic run_drain(input int stall_at, input bit rand_in, input int rst_at,
                             input bit b2b, input logic [31:0] next_m0);
        int n;
        int stalled;
        bit did_rst;
        n       = 0;
        stalled = 0;
        did_rst = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            if (rst_at >= 0 && out_valid && int'(out_idx) == rst_at) begin
                rst = 1'b1;
                exp_q.delete();
                #1;
                check_reset_vals();
                @(posedge clk);
                #1;
                rst     = 1'b0;
                did_rst = 1'b1;
                break;
            end
            out_ready = 1'b1;
            if (stall_at >= 0 && out_valid && int'(out_idx) == stall_at && stalled < 5) begin
                out_ready = 1'b0;
                stalled++;
            end
            if (rand_in) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
            end else if (b2b) begin
                in_valid = 1'b1;
                in_word  = next_m0;
            end
            if (out_valid) begin
                chk("run_in_ready", 32'(in_ready), 32'd0);
                chk("run_busy", 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
        end
        if (!did_rst) begin
            chk("in_ready_after_last", 32'(in_ready), 32'd1);
            chk("out_valid_after_last", 32'(out_valid), 32'd0);
        end
        if (rand_in) in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        blk_t abc, b1, b2, zb;
        for (int i = 0; i < 16; i++) begin
            abc[i] = 32'h0;
            zb[i]  = 32'h0;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        known[0]  = 32'h61626380;
        known[15] = 32'h00000018;
        known[16] = 32'h61626380;
        known[17] = 32'h000F0000;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        out_ready = 1'b1;
        #12;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "abc" at full rate
        abc_chk = 1'b1;
        load_block(abc, 1'b0, 1'b0);
        run_drain(-1, 1'b0, -1, 1'b0, 32'h0);

        // "abc" with gapped input
        load_block(abc, 1'b1, 1'b0);
        run_drain(-1, 1'b0, -1, 1'b0, 32'h0);
        abc_chk = 1'b0;

        // Random block with 5-cycle backpressure at index 20
        for (int i = 0; i < 16; i++) b1[i] = $urandom;
        load_block(b1, 1'b0, 1'b0);
        run_drain(20, 1'b0, -1, 1'b0, 32'h0);

        // Random block with input noise during RUN
        for (int i = 0; i < 16; i++) b1[i] = $urandom;
        load_block(b1, 1'b0, 1'b0);
        run_drain(-1, 1'b1, -1, 1'b0, 32'h0);

        // Reset at index 30, then an all-zero block
        for (int i = 0; i < 16; i++) b1[i] = $urandom;
        load_block(b1, 1'b0, 1'b0);
        run_drain(-1, 1'b0, 30, 1'b0, 32'h0);
        load_block(zb, 1'b0, 1'b0);
        run_drain(-1, 1'b0, -1, 1'b0, 32'h0);

        // Back-to-back blocks with in_valid held high
        for (int i = 0; i < 16; i++) begin
            b1[i] = $urandom;
            b2[i] = $urandom;
        end
        load_block(b1, 1'b0, 1'b1);
        run_drain(-1, 1'b0, -1, 1'b1, b2[0]);
        load_block(b2, 1'b0, 1'b0);
        run_drain(-1, 1'b0, -1, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
